// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side command path: FSM encoding,
// default frame marker and the frame checksum.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_ISSUE = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // XOR of every frame byte except the checksum itself
  function automatic logic [7:0] calc_csum(input logic [7:0] sync_byte,
                                           input logic [7:0] addr,
                                           input logic [7:0] data);
    return sync_byte ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_timeout_timer.sv
// Inter-byte gap timer: counts enabled clocks since the last clear and flags
// the cycle in which the gap reaches TIMEOUT_CLKS.
module uart_timeout_timer #(
  parameter int TIMEOUT_CLKS = 1740
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expire
);

  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CLKS - 1);
  localparam logic [CW-1:0] MAX_COUNT  = CW'(TIMEOUT_CLKS);

  logic [CW-1:0] count_r;

  // gap counter, held at MAX_COUNT so it can never wrap
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      count_r <= '0;
    end else if (i_Clear) begin
      count_r <= '0;
    end else if (i_Enable && (count_r != MAX_COUNT)) begin
      count_r <= count_r + CW'(1);
    end
  end

  // a clear in the same cycle (byte arrival) overrides expiry
  always_comb begin
    o_Expire = i_Enable && !i_Clear && (count_r == LAST_COUNT);
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame-level controller: hunts for SYNC_BYTE, collects address/data/checksum,
// issues one register write over valid/ready and reports framing errors.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 87,
  parameter int         TIMEOUT_BITS = 20,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Wr_Valid,
  input  logic       i_Wr_Ready,
  output logic [7:0] o_Wr_Addr,
  output logic [7:0] o_Wr_Data,
  output logic       o_Csum_Err,
  output logic       o_Timeout,
  output logic       o_Overrun,
  output logic [7:0] o_Err_Count
);

  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;

  state_t     state_r;
  state_t     next_state_s;
  logic [7:0] addr_r;
  logic [7:0] data_r;
  logic       wr_valid_r;
  logic       csum_err_r;
  logic       timeout_r;
  logic       overrun_r;
  logic [7:0] err_count_r;

  logic       addr_load_s;
  logic       data_load_s;
  logic       csum_err_s;
  logic       timeout_s;
  logic       overrun_s;
  logic       err_inc_s;
  logic       timer_clear_s;
  logic       timer_en_s;
  logic       expire_s;
  logic       is_sync_s;

  // the timer only runs while a frame is partially received
  always_comb begin
    is_sync_s     = i_Rx_DV && (i_Rx_Byte == SYNC_BYTE);
    timer_en_s    = (state_r == ST_ADDR) || (state_r == ST_DATA) || (state_r == ST_CSUM);
    timer_clear_s = (state_r == ST_IDLE) || (state_r == ST_ISSUE) || i_Rx_DV;
  end

  uart_timeout_timer #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timer (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (timer_clear_s),
    .i_Enable (timer_en_s),
    .o_Expire (expire_s)
  );

  // next-state and single-cycle event decode
  always_comb begin
    next_state_s = state_r;
    addr_load_s  = 1'b0;
    data_load_s  = 1'b0;
    csum_err_s   = 1'b0;
    timeout_s    = 1'b0;
    overrun_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (is_sync_s) begin
          next_state_s = ST_ADDR;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (i_Rx_DV) begin
          addr_load_s  = 1'b1;
          next_state_s = ST_DATA;
        end else if (expire_s) begin
          timeout_s    = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (i_Rx_DV) begin
          data_load_s  = 1'b1;
          next_state_s = ST_CSUM;
        end else if (expire_s) begin
          timeout_s    = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == calc_csum(SYNC_BYTE, addr_r, data_r)) begin
            next_state_s = ST_ISSUE;
          end else begin
            csum_err_s   = 1'b1;
            next_state_s = ST_IDLE;
          end
        end else if (expire_s) begin
          timeout_s    = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_CSUM;
        end
      end
      ST_ISSUE: begin
        // a completing write frees the byte to be hunted as in IDLE
        if (i_Wr_Ready) begin
          if (is_sync_s) begin
            next_state_s = ST_ADDR;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else if (i_Rx_DV) begin
          overrun_s    = 1'b1;
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
    err_inc_s = csum_err_s || timeout_s || overrun_s;
  end

  // state, command and error registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_r     <= ST_IDLE;
      addr_r      <= 8'h00;
      data_r      <= 8'h00;
      wr_valid_r  <= 1'b0;
      csum_err_r  <= 1'b0;
      timeout_r   <= 1'b0;
      overrun_r   <= 1'b0;
      err_count_r <= 8'h00;
    end else begin
      state_r    <= next_state_s;
      wr_valid_r <= (next_state_s == ST_ISSUE);
      csum_err_r <= csum_err_s;
      timeout_r  <= timeout_s;
      overrun_r  <= overrun_s;
      if (addr_load_s) begin
        addr_r <= i_Rx_Byte;
      end
      if (data_load_s) begin
        data_r <= i_Rx_Byte;
      end
      if (err_inc_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'd1;
      end
    end
  end

  assign o_Wr_Valid  = wr_valid_r;
  assign o_Wr_Addr   = addr_r;
  assign o_Wr_Data   = data_r;
  assign o_Csum_Err  = csum_err_r;
  assign o_Timeout   = timeout_r;
  assign o_Overrun   = overrun_r;
  assign o_Err_Count = err_count_r;

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Frame-level controller for the UART receive path. Consumes the byte strobe and byte from the UART receiver, hunts for a sync byte, assembles a 4-byte write command (sync, address, data, checksum), validates it, and issues one register write over a valid/ready handshake. It also enforces an inter-byte timeout and reports checksum, timeout and overrun errors through pulses and a saturating error counter.

## Interface

- CLKS_PER_BIT, 87: clocks per UART bit; matches the receiver's value and scales the timeout.
- TIMEOUT_BITS, 20: inter-byte timeout in bit times; TIMEOUT_CLKS = TIMEOUT_BITS*CLKS_PER_BIT.
- SYNC_BYTE, 8'hA5: frame start marker.
- i_Clock  in  1  sole clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Rx_DV  in  1  one-cycle strobe: i_Rx_Byte is valid.
- i_Rx_Byte  in  8  received byte.
- o_Wr_Valid  out  1  write command pending.
- i_Wr_Ready  in  1  register sink accepts the command.
- o_Wr_Addr  out  8  write address; stable while o_Wr_Valid=1.
- o_Wr_Data  out  8  write data; stable while o_Wr_Valid=1.
- o_Csum_Err  out  1  one-cycle pulse on checksum mismatch.
- o_Timeout  out  1  one-cycle pulse on inter-byte timeout.
- o_Overrun  out  1  one-cycle pulse when a byte is dropped during ISSUE.
- o_Err_Count  out  8  saturating count of all errors.

## Operation

- States: IDLE, ADDR, DATA, CSUM, ISSUE.
- IDLE: on i_Rx_DV with byte==SYNC_BYTE, go to ADDR. Any other byte is discarded silently, with no error.
- ADDR: on i_Rx_DV, latch the address and go to DATA.
- DATA: on i_Rx_DV, latch the data and go to CSUM.
- CSUM: on i_Rx_DV, compare the byte with SYNC_BYTE ^ addr ^ data.
  - Match: go to ISSUE.
  - Mismatch: pulse o_Csum_Err and go to IDLE.
- ISSUE: o_Wr_Valid=1. When i_Wr_Ready=1, the transfer completes and the state returns to IDLE.
- Byte during ISSUE:
  - If i_Wr_Ready=0 in that cycle, the byte is dropped and o_Overrun pulses.
  - If i_Wr_Ready=1 in the same cycle, the write completes and the byte is evaluated as in IDLE, so a SYNC_BYTE goes directly to ADDR.
- Timeout counter:
  - Width $clog2(TIMEOUT_CLKS+1).
  - Cleared in IDLE, in ISSUE, and on every i_Rx_DV. Increments each clock in ADDR, DATA and CSUM.
  - When it reaches TIMEOUT_CLKS-1 with no byte arriving, o_Timeout pulses and the state goes to IDLE.
  - A byte arriving in the expiry cycle wins: no timeout, normal transition.
- o_Err_Count: increments by 1 on any error pulse and saturates at 255. The three error sources are mutually exclusive by state, so at most one increment occurs per cycle.
- Reset, including mid-frame or mid-ISSUE: state goes to IDLE and every output and register clears. The pending write is abandoned.

## Timing

- Reset values: o_Wr_Valid=0, o_Wr_Addr=0, o_Wr_Data=0, o_Csum_Err=0, o_Timeout=0, o_Overrun=0, o_Err_Count=0.
- All outputs are registered.
- o_Wr_Valid rises the clock after the valid checksum strobe (latency 1).
- Write handshake: a transfer occurs on any edge with o_Wr_Valid & i_Wr_Ready. o_Wr_Valid falls the following cycle. Maximum throughput is one command per 4 UART bytes.
- Error pulses are asserted the clock after the causing event and last exactly 1 cycle. o_Err_Count updates in the same cycle as the pulse.
- o_Wr_Addr and o_Wr_Data hold their last values after the transfer until the next frame overwrites them.

## Structure

- Shared package uart_pkg:
  - state encoding constants (3-bit: IDLE=0, ADDR=1, DATA=2, CSUM=3, ISSUE=4);
  - default SYNC_BYTE;
  - the checksum function.
- One sub-module is natural: uart_timeout_timer (clear, enable, expire pulse; parameter TIMEOUT_CLKS). The parser FSM, handshake and error counter stay in uart_cmd_parser.

## Test plan

- Happy path: bytes A5,10,3C,89 (89 = A5^10^3C), i_Wr_Ready=1 → one-cycle o_Wr_Valid with o_Wr_Addr=10, o_Wr_Data=3C; no errors.
- Bad checksum: bytes A5,10,3C,00 → o_Csum_Err pulse, o_Err_Count=1, no o_Wr_Valid. A following valid frame is accepted.
- Timeout (CLKS_PER_BIT=4, TIMEOUT_BITS=2): A5,10, then 8 idle clocks → o_Timeout pulse and return to IDLE. A byte on the 8th clock suppresses the timeout.
- Backpressure: valid frame with i_Wr_Ready=0 for 20 cycles while byte 55 arrives:
  - o_Overrun pulses;
  - addr and data stay stable;
  - the write completes when ready rises.
  - Repeat with ready and A5 arriving in the same cycle → next frame starts without loss.
- Saturation and reset: 300 bad frames → o_Err_Count=255. Assert i_Reset mid-ISSUE → all outputs 0 asynchronously, and the FSM restarts in IDLE.
- Hunt: bytes 00,FF,A5,01,02,A6 → exactly one write with addr 01, data 02; no errors from the leading junk.
